// File: rtl/bcd_pkg.sv
// ============================================================================
// bcd_pkg : shared BCD constants and the load-path nibble clamp
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// bcd_digit : combinational single-digit BCD up/down step with carry/borrow
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bcd_digit
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dir,
  input  logic       cin,
  output logic [3:0] next_digit,
  output logic       cout
);

  // cout doubles as "this digit sits at the limit" when cin is set
  always_comb begin
    next_digit = digit;
    cout       = 1'b0;
    if (cin) begin
      if (dir) begin
        if (digit >= BCD_MAX) begin
          next_digit = 4'd0;
          cout       = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end else begin
        if (digit == 4'd0) begin
          next_digit = BCD_MAX;
          cout       = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_counter.sv
// ============================================================================
// bcd_counter : N-digit packed-BCD up/down counter with clamped load,
//               wrap or saturate at the limits
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int SATURATE = 0
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Enable,
  input  logic                  Up,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadValue,
  output logic [4*DIGITS-1:0]   Count,
  output logic                  Wrap,
  output logic                  AtLimit,
  output logic                  Invalid
);

  localparam int W      = DIGITS * BCD_W;
  localparam bit SAT_EN = (SATURATE != 0);

  logic [W-1:0]    count_q, count_d;
  logic            wrap_q, wrap_d;
  logic            invalid_q, invalid_d;
  logic [W-1:0]    step_value;
  logic [W-1:0]    load_clamped;
  logic            load_has_bad;
  logic [DIGITS:0] carry;

  // Ripple chain seeded with a step request on digit 0; the final carry
  // means every digit was at its limit for the current direction.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .digit      (count_q[i*BCD_W +: BCD_W]),
      .dir        (Up),
      .cin        (carry[i]),
      .next_digit (step_value[i*BCD_W +: BCD_W]),
      .cout       (carry[i+1])
    );
  end

  assign AtLimit = carry[DIGITS];

  always_comb begin
    load_clamped = '0;
    load_has_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[i*BCD_W +: BCD_W] = bcd_clamp(LoadValue[i*BCD_W +: BCD_W]);
      if (LoadValue[i*BCD_W +: BCD_W] > BCD_MAX) load_has_bad = 1'b1;
    end
  end

  always_comb begin
    count_d   = count_q;
    wrap_d    = 1'b0;
    invalid_d = 1'b0;
    if (Load) begin
      count_d   = load_clamped;
      invalid_d = load_has_bad;
    end else if (Enable) begin
      if (!AtLimit) begin
        count_d = step_value;
      end else if (!SAT_EN) begin
        // at the limit the chain already yields all-0s or all-9s
        count_d = step_value;
        wrap_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      count_q   <= '0;
      wrap_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      invalid_q <= invalid_d;
    end
  end

  assign Count   = count_q;
  assign Wrap    = wrap_q;
  assign Invalid = invalid_q;

endmodule

`default_nettype wire
